muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers. Sits directly downstream of the register file.
- Consumes the rsContent/rtContent read operands for MULT, MULTU, DIV and DIVU, and services MTHI/MTLO.
- Exposes HI/LO to the writeback mux for MFHI/MFLO.
- Controller stalls the pipeline on busy.

---
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply/divide unit with architectural HI/LO.
// Shift-add multiply, restoring divide, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rsContent,
  input  logic [XLEN-1:0] rtContent,
  input  logic            mthi,
  input  logic            mtlo,
  output logic            busy,
  output logic            done,
  output logic            divByZero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_div;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_dz;
  logic [XLEN-1:0]     r_m;
  logic [XLEN-1:0]     r_rs;
  logic [2*XLEN-1:0]   r_p;

  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic [XLEN:0]       w_add;
  logic [2*XLEN-1:0]   w_mul_nx;
  logic [XLEN:0]       w_rs;
  logic                w_ge;
  logic [XLEN-1:0]     w_diff;
  logic [2*XLEN-1:0]   w_div_nx;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_q;
  logic [XLEN-1:0]     w_r;

  assign w_a_neg = op[0] & rsContent[XLEN-1];
  assign w_b_neg = op[0] & rtContent[XLEN-1];
  assign w_a_mag = w_a_neg ? -rsContent : rsContent;
  assign w_b_mag = w_b_neg ? -rtContent : rtContent;

  // Multiply: P = {acc, multiplier}; add on LSB, shift right
  assign w_add = {1'b0, r_p[2*XLEN-1:XLEN]}
               + {1'b0, (r_p[0] ? r_m : {XLEN{1'b0}})};
  assign w_mul_nx = {w_add, r_p[XLEN-1:1]};

  // Divide: P = {remainder, quotient}; shift left, trial subtract
  assign w_rs = {r_p[2*XLEN-1:XLEN], r_p[XLEN-1]};
  assign w_ge = w_rs >= {1'b0, r_m};
  assign w_diff = w_rs[XLEN-1:0] - r_m;
  assign w_div_nx = {(w_ge ? w_diff : w_rs[XLEN-1:0]),
                     r_p[XLEN-2:0], w_ge};

  assign w_prod = r_neg_q ? -r_p : r_p;
  assign w_q = r_neg_q ? -r_p[XLEN-1:0] : r_p[XLEN-1:0];
  assign w_r = r_neg_r ? -r_p[2*XLEN-1:XLEN]
                       : r_p[2*XLEN-1:XLEN];

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div     <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      r_m       <= '0;
      r_rs      <= '0;
      r_p       <= '0;
      done      <= 1'b0;
      divByZero <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_CALC;
            r_cnt     <= '0;
            r_div     <= op[1];
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= op[1] & w_a_neg;
            r_dz      <= op[1] & (rtContent == '0);
            r_rs      <= rsContent;
            r_m       <= op[1] ? w_b_mag : w_a_mag;
            r_p       <= {{XLEN{1'b0}},
                          (op[1] ? w_a_mag : w_b_mag)};
            divByZero <= 1'b0;
          end else begin
            if (mthi) hi <= rsContent;
            if (mtlo) lo <= rsContent;
          end
        end
        S_CALC: begin
          r_p   <= r_div ? w_div_nx : w_mul_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state <= S_IDLE;
          done    <= 1'b1;
          if (!r_div) begin
            hi <= w_prod[2*XLEN-1:XLEN];
            lo <= w_prod[XLEN-1:0];
          end else if (r_dz) begin
            hi        <= r_rs;
            lo        <= '1;
            divByZero <= 1'b1;
          end else begin
            hi <= w_r;
            lo <= w_q;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, scoreboard,
// and hand sequences for reset, start/mthi hazards.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rsContent;
  logic [31:0] rtContent;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .rsContent(rsContent),
    .rtContent(rtContent),
    .mthi(mthi),
    .mtlo(mtlo),
    .busy(busy),
    .done(done),
    .divByZero(divByZero),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] o,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] h, input logic [31:0] l,
                              input logic d);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.hi = h; v.lo = l; v.dz = d;
    return v;
  endfunction

  // Called at a negedge with the DUT idle. poke>=0 injects a hazard
  // (extra start, or mthi) in the cycle sampled at edge E(poke+1).
  task automatic issue(input vec_t v, input int poke, input bit poke_mthi);
    exp_t e;
    int n;
    bit got;
    bit busy_ok;
    start = 1'b1;
    op = v.op;
    rsContent = v.a;
    rtContent = v.b;
    e.hi = v.hi; e.lo = v.lo; e.dz = v.dz;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rsContent = $urandom;
    rtContent = $urandom;
    chk("busy_after_e0", {31'b0, busy}, 32'd1);
    n = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    while (n < 40 && !got) begin
      if (n == poke) begin
        if (poke_mthi) begin
          mthi = 1'b1;
          rsContent = 32'hAAAA5555;
        end else begin
          start = 1'b1;
          op = ~v.op;
        end
      end
      @(posedge clk);
      @(negedge clk);
      n++;
      start = 1'b0;
      mthi = 1'b0;
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk("latency", n, 32'd33);
      chk("busy_held", {31'b0, busy_ok}, 32'd1);
      chk("busy_at_done", {31'b0, busy}, 32'd0);
      chk("hi", hi, e.hi);
      chk("lo", lo, e.lo);
      chk("divByZero", {31'b0, divByZero}, {31'b0, e.dz});
    end
  endtask

  initial begin
    bit seen_done;
    bit seen_busy;
    rst = 1'b0;
    start = 1'b0;
    op = 2'b00;
    rsContent = '0;
    rtContent = '0;
    mthi = 1'b0;
    mtlo = 1'b0;

    tbl.push_back(mk(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0));
    tbl.push_back(mk(2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0));
    tbl.push_back(mk(2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0));
    tbl.push_back(mk(2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0));
    tbl.push_back(mk(2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1));
    tbl.push_back(mk(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0));
    tbl.push_back(mk(2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0));
    tbl.push_back(mk(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0));
    tbl.push_back(mk(2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1));
    tbl.push_back(mk(2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0));
    tbl.push_back(mk(2'b11, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        1'b0));
    tbl.push_back(mk(2'b10, 32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF, 1'b0));

    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dz", {31'b0, divByZero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // back-to-back: each start lands on the edge after the done pulse
    for (int i = 0; i < tbl.size(); i++) issue(tbl[i], -1, 1'b0);

    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);

    // start pulsed again at E5 is ignored
    issue(mk(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0), 4, 1'b0);
    @(negedge clk);
    chk("no_second_op", {31'b0, busy}, 32'd0);

    // mthi while busy has no effect
    issue(mk(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0), 6, 1'b1);

    mthi = 1'b1;
    rsContent = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_idle_hi", hi, 32'hAAAA5555);
    chk("mthi_idle_lo", lo, 32'd12);

    mthi = 1'b1;
    mtlo = 1'b1;
    rsContent = 32'h13579BDF;
    @(posedge clk);
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mthilo_hi", hi, 32'h13579BDF);
    chk("mthilo_lo", lo, 32'h13579BDF);

    // mtlo in the same cycle as start is ignored
    start = 1'b1;
    mtlo = 1'b1;
    op = 2'b01;
    rsContent = 32'h00000009;
    rtContent = 32'h00000009;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mtlo = 1'b0;
    chk("mtlo_with_start", lo, 32'h13579BDF);

    // reset at E10 of this MULT abandons it
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    chk("midrst_no_done", {31'b0, seen_done}, 32'd0);
    chk("midrst_no_busy", {31'b0, seen_busy}, 32'd0);
    chk("midrst_hi_kept", hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
